// File: rtl/fm_op_seq.sv
// Operator-slot sequencer: steps op_sel through every operator once per sample pass,
// strobes write-back, captures env/restart, and generates the tremolo am_val.
// Optional vibrato position counter: define FM_SEQ_VIB_EN.
module fm_op_seq #(
  parameter int NUM_OPS       = 36,
  parameter int SLOT_CYCLES   = 4,
  parameter int TREM_DIV_LOG2 = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       reset_all,
  input  logic       am_depth,
  input  logic       clr_overrun,
  input  logic [8:0] env,
  input  logic       restart,
  output logic [5:0] op_sel,
  output logic       next,
  output logic       op_reset,
  output logic [5:0] am_val,
  output logic       env_strobe,
  output logic [8:0] env_out,
  output logic [5:0] env_op,
  output logic       env_restart,
  output logic       pass_done,
  output logic       overrun,
  output logic [2:0] vib_pos
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] OP_LAST   = 6'(NUM_OPS - 1);
  localparam logic [3:0] SLOT_LAST = 4'(SLOT_CYCLES - 1);
  localparam logic [7:0] POS_LAST  = 8'd209;
  localparam logic [7:0] POS_PEAK  = 8'd104;

  state_t                   state_q, state_d;
  logic [5:0]               op_sel_q, op_sel_d;
  logic [3:0]               slot_q, slot_d;
  logic                     next_q, next_d;
  logic                     pass_done_q, pass_done_d;
  logic                     pending_q, pending_d;
  logic                     active_q, active_d;
  logic                     overrun_q, overrun_d;
  logic                     env_strobe_q, env_strobe_d;
  logic [8:0]               env_out_q, env_out_d;
  logic [5:0]               env_op_q, env_op_d;
  logic                     env_restart_q, env_restart_d;
  logic [TREM_DIV_LOG2-1:0] samp_q, samp_d;
  logic [7:0]               pos_q, pos_d;
  logic [5:0]               am_val_q, am_val_d;
  logic [7:0]               tri_lvl;

  always_comb begin
    state_d       = state_q;
    op_sel_d      = op_sel_q;
    slot_d        = slot_q;
    pass_done_d   = 1'b0;
    active_d      = active_q;
    pending_d     = pending_q | reset_all;
    overrun_d     = overrun_q;
    samp_d        = samp_q;
    pos_d         = pos_q;
    am_val_d      = am_val_q;
    tri_lvl       = '0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d   = RUN;
          op_sel_d  = '0;
          slot_d    = '0;
          // A request arriving in the entry cycle is kept for the following pass.
          active_d  = pending_q;
          pending_d = reset_all;
        end
      end
      RUN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (op_sel_q == OP_LAST) begin
            state_d     = IDLE;
            op_sel_d    = '0;
            active_d    = 1'b0;
            pass_done_d = 1'b1;
          end else begin
            op_sel_d = op_sel_q + 6'd1;
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
    endcase

    // Registered strobe must line up with the slot count it is computed from.
    next_d = (state_d == RUN) && (slot_d == SLOT_LAST);

    if (sample_tick && (state_q == RUN)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    env_strobe_d  = next_q;
    env_out_d     = next_q ? env      : env_out_q;
    env_op_d      = next_q ? op_sel_q : env_op_q;
    env_restart_d = next_q ? restart  : env_restart_q;

    if (pass_done_q) begin
      samp_d = samp_q + TREM_DIV_LOG2'(1);
      if (&samp_q) begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 8'd1;
      end
    end

    tri_lvl = (pos_q <= POS_PEAK) ? pos_q : POS_LAST - pos_q;
    if (state_q == IDLE) begin
      am_val_d = am_depth ? 6'(tri_lvl >> 2) : 6'(tri_lvl >> 4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_sel_q      <= '0;
      slot_q        <= '0;
      next_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      pending_q     <= 1'b0;
      active_q      <= 1'b0;
      overrun_q     <= 1'b0;
      env_strobe_q  <= 1'b0;
      env_out_q     <= '0;
      env_op_q      <= '0;
      env_restart_q <= 1'b0;
      samp_q        <= '0;
      pos_q         <= '0;
      am_val_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_sel_q      <= op_sel_d;
      slot_q        <= slot_d;
      next_q        <= next_d;
      pass_done_q   <= pass_done_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      overrun_q     <= overrun_d;
      env_strobe_q  <= env_strobe_d;
      env_out_q     <= env_out_d;
      env_op_q      <= env_op_d;
      env_restart_q <= env_restart_d;
      samp_q        <= samp_d;
      pos_q         <= pos_d;
      am_val_q      <= am_val_d;
    end
  end

  assign op_sel      = op_sel_q;
  assign next        = next_q;
  assign op_reset    = active_q;
  assign am_val      = am_val_q;
  assign env_strobe  = env_strobe_q;
  assign env_out     = env_out_q;
  assign env_op      = env_op_q;
  assign env_restart = env_restart_q;
  assign pass_done   = pass_done_q;
  assign overrun     = overrun_q;

`ifdef FM_SEQ_VIB_EN
  logic [9:0] vib_cnt_q, vib_cnt_d;
  logic [2:0] vib_pos_q, vib_pos_d;

  always_comb begin
    vib_cnt_d = vib_cnt_q;
    vib_pos_d = vib_pos_q;
    if (pass_done_q) begin
      vib_cnt_d = vib_cnt_q + 10'd1;
      if (&vib_cnt_q) begin
        vib_pos_d = vib_pos_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vib_cnt_q <= '0;
      vib_pos_q <= '0;
    end else begin
      vib_cnt_q <= vib_cnt_d;
      vib_pos_q <= vib_pos_d;
    end
  end

  assign vib_pos = vib_pos_q;
`else
  assign vib_pos = '0;
`endif

endmodule
